// File: rtl/pixel_proc_pkg.sv
// Shared definitions for the pixel stream processor.
// FSM states, mode codes, err bit indices and per-channel helpers.
package pixel_proc_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_LINE  = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_ADD    = 2'b01;
  localparam logic [1:0] MODE_SUB    = 2'b10;
  localparam logic [1:0] MODE_THR    = 2'b11;

  localparam int ERR_SHORT = 0;
  localparam int ERR_LONG  = 1;
  localparam int ERR_ABORT = 2;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // 9-bit add/sub; bit 8 flags overflow (add) or borrow (sub)
  function automatic logic [8:0] pre_op(
    input logic [7:0] x,
    input logic [1:0] m,
    input logic [7:0] v
  );
    logic [8:0] y;
    case (m)
      MODE_ADD: y = {1'b0, x} + {1'b0, v};
      MODE_SUB: y = {1'b0, x} - {1'b0, v};
      default:  y = {1'b0, x};
    endcase
    return y;
  endfunction

  // Clamp the 9-bit intermediate, or expand the threshold bit
  function automatic logic [7:0] post_op(
    input logic [8:0] y,
    input logic [1:0] m,
    input logic       hi
  );
    logic [7:0] o;
    case (m)
      MODE_ADD: o = y[8] ? 8'hFF : y[7:0];
      MODE_SUB: o = y[8] ? 8'h00 : y[7:0];
      MODE_THR: o = hi ? 8'hFF : 8'h00;
      default:  o = y[7:0];
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pixel_point_op_lane.sv
// One-pixel, two-stage point operation (bypass/add/sub/threshold).
// SAT_COUNT_EN adds a per-channel clamp flag output.
module pixel_point_op_lane
  import pixel_proc_pkg::*;
#(
  parameter int VALUE     = 100,
  parameter int THRESHOLD = 90
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       en1_i,
  input  logic       en2_i,
  input  logic [1:0] mode_i,
  input  rgb_t       pix_i,
  output rgb_t       pix_o
`ifdef SAT_COUNT_EN
  ,
  output logic [2:0] clamp_o
`endif
);

  localparam logic [7:0] VAL8 = 8'(VALUE);
  localparam logic [9:0] THR3 = 10'(3 * THRESHOLD);

  logic [8:0] r_q, g_q, b_q;
  logic [8:0] r_d, g_d, b_d;
  logic       hi_q, hi_d;
  logic [1:0] m_q;
  logic [9:0] sum;
  rgb_t       pix_q, pix_d;

  // Stage-1 arithmetic: 9-bit add/sub and 10-bit luma-ish sum compare
  always_comb begin
    sum  = {2'b0, pix_i.r} + {2'b0, pix_i.g} + {2'b0, pix_i.b};
    hi_d = (sum > THR3);
    r_d  = pre_op(pix_i.r, mode_i, VAL8);
    g_d  = pre_op(pix_i.g, mode_i, VAL8);
    b_d  = pre_op(pix_i.b, mode_i, VAL8);
  end

  // Stage-1 registers, loaded only for accepted pairs
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      hi_q <= 1'b0;
      m_q  <= MODE_BYPASS;
    end else if (en1_i) begin
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
      hi_q <= hi_d;
      m_q  <= mode_i;
    end
  end

  // Stage-2 clamp / threshold expansion
  always_comb begin
    pix_d.r = post_op(r_q, m_q, hi_q);
    pix_d.g = post_op(g_q, m_q, hi_q);
    pix_d.b = post_op(b_q, m_q, hi_q);
  end

  // Output register holds its value while the stream is idle
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pix_q <= '0;
    end else if (en2_i) begin
      pix_q <= pix_d;
    end
  end

  assign pix_o = pix_q;

`ifdef SAT_COUNT_EN
  assign clamp_o = (m_q == MODE_ADD || m_q == MODE_SUB) ?
                   {r_q[8], g_q[8], b_q[8]} : 3'b000;
`endif

endmodule

// File: rtl/pixel_stream_proc.sv
// Pixel stream processor: framing FSM, geometry checks, 2-stage point op.
// Optional SAT_COUNT_EN enables the per-frame clamped-byte counter.
module pixel_stream_proc
  import pixel_proc_pkg::*;
#(
  parameter int WIDTH     = 768,
  parameter int HEIGHT    = 512,
  parameter int VALUE     = 100,
  parameter int THRESHOLD = 90
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [1:0]  mode,
  input  logic        VSYNC_IN,
  input  logic        HSYNC_IN,
  input  logic [7:0]  DATA_R0_IN,
  input  logic [7:0]  DATA_G0_IN,
  input  logic [7:0]  DATA_B0_IN,
  input  logic [7:0]  DATA_R1_IN,
  input  logic [7:0]  DATA_G1_IN,
  input  logic [7:0]  DATA_B1_IN,
  output logic        VSYNC_OUT,
  output logic        HSYNC_OUT,
  output logic [7:0]  DATA_R0_OUT,
  output logic [7:0]  DATA_G0_OUT,
  output logic [7:0]  DATA_B0_OUT,
  output logic [7:0]  DATA_R1_OUT,
  output logic [7:0]  DATA_G1_OUT,
  output logic [7:0]  DATA_B1_OUT,
  output logic [9:0]  row_idx,
  output logic        frame_done,
  output logic [2:0]  err,
  output logic [19:0] sat_count
);

  localparam logic [9:0] COL_LAST = 10'(WIDTH / 2 - 1);
  localparam logic [9:0] ROW_LAST = 10'(HEIGHT - 1);

  logic [2:0] state_q, state_d;
  logic [9:0] col_q, col_d;
  logic [9:0] row_q, row_d;
  logic [1:0] mode_q, mode_d;
  logic [2:0] err_q, err_d;
  logic       dcnt_q, dcnt_d;
  logic       fdone_q, fdone_d;
  logic       vs_q, hs_q;
  logic       vs_rise;
  logic       acc;

  logic       vld_s1_q, vld_s2_q;
  logic [9:0] row_s1_q, row_o_q;
  logic       vs_d1_q, vs_d2_q;

  rgb_t       in0, in1, out0, out1;

  assign vs_rise = VSYNC_IN & ~vs_q;

  // Framing FSM: arm on VSYNC edge, count pairs/lines, flag geometry errors
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    mode_d  = mode_q;
    err_d   = err_q;
    dcnt_d  = dcnt_q;
    fdone_d = 1'b0;
    acc     = 1'b0;
    if (vs_rise) begin
      if (state_q != ST_IDLE) err_d[ERR_ABORT] = 1'b1;
      state_d = ST_ARMED;
      mode_d  = mode;
      col_d   = '0;
      row_d   = '0;
      dcnt_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_ARMED: acc = HSYNC_IN;
        ST_LINE: begin
          if (HSYNC_IN) begin
            acc = 1'b1;
          end else begin
            err_d[ERR_SHORT] = 1'b1;
            row_d   = row_q + 10'd1;
            col_d   = '0;
            state_d = ST_GAP;
          end
        end
        ST_GAP: begin
          if (HSYNC_IN && !hs_q) acc = 1'b1;
          else if (HSYNC_IN) err_d[ERR_LONG] = 1'b1;
        end
        ST_DONE: begin
          if (dcnt_q) begin
            fdone_d = 1'b1;
            dcnt_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            dcnt_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (acc) begin
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q == ROW_LAST) begin
            state_d = ST_DONE;
          end else begin
            row_d   = row_q + 10'd1;
            state_d = ST_GAP;
          end
        end else begin
          col_d   = col_q + 10'd1;
          state_d = ST_LINE;
        end
      end
    end
  end

  // FSM, counters and sticky error state
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      mode_q  <= MODE_BYPASS;
      err_q   <= '0;
      dcnt_q  <= 1'b0;
      fdone_q <= 1'b0;
      vs_q    <= 1'b0;
      hs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      dcnt_q  <= dcnt_d;
      fdone_q <= fdone_d;
      vs_q    <= VSYNC_IN;
      hs_q    <= HSYNC_IN;
    end
  end

  // Valid, row and VSYNC delay lines matching the 2-stage datapath
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      vld_s1_q <= 1'b0;
      vld_s2_q <= 1'b0;
      row_s1_q <= '0;
      row_o_q  <= '0;
      vs_d1_q  <= 1'b0;
      vs_d2_q  <= 1'b0;
    end else begin
      vld_s1_q <= acc;
      vld_s2_q <= vld_s1_q;
      if (acc) row_s1_q <= row_q;
      if (vld_s1_q) row_o_q <= row_s1_q;
      vs_d1_q  <= VSYNC_IN;
      vs_d2_q  <= vs_d1_q;
    end
  end

  assign in0 = {DATA_R0_IN, DATA_G0_IN, DATA_B0_IN};
  assign in1 = {DATA_R1_IN, DATA_G1_IN, DATA_B1_IN};

`ifdef SAT_COUNT_EN
  logic [2:0]  cl0, cl1;
`endif

  pixel_point_op_lane #(
    .VALUE     (VALUE),
    .THRESHOLD (THRESHOLD)
  ) u_lane0 (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .en1_i   (acc),
    .en2_i   (vld_s1_q),
    .mode_i  (mode_q),
    .pix_i   (in0),
    .pix_o   (out0)
`ifdef SAT_COUNT_EN
    ,
    .clamp_o (cl0)
`endif
  );

  pixel_point_op_lane #(
    .VALUE     (VALUE),
    .THRESHOLD (THRESHOLD)
  ) u_lane1 (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .en1_i   (acc),
    .en2_i   (vld_s1_q),
    .mode_i  (mode_q),
    .pix_i   (in1),
    .pix_o   (out1)
`ifdef SAT_COUNT_EN
    ,
    .clamp_o (cl1)
`endif
  );

`ifdef SAT_COUNT_EN
  logic [19:0] sat_q, sat_d;
  logic [20:0] sat_sum;
  logic [2:0]  ncl;

  // Add this cycle's clamped bytes; saturate; restart on frame arm
  always_comb begin
    ncl = {2'b0, cl0[0]} + {2'b0, cl0[1]} + {2'b0, cl0[2]}
        + {2'b0, cl1[0]} + {2'b0, cl1[1]} + {2'b0, cl1[2]};
    sat_sum = {1'b0, sat_q} + {18'b0, ncl};
    sat_d   = sat_q;
    if (vs_rise) sat_d = '0;
    else if (vld_s1_q) sat_d = sat_sum[20] ? '1 : sat_sum[19:0];
  end

  // Saturation counter register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) sat_q <= '0;
    else sat_q <= sat_d;
  end

  assign sat_count = sat_q;
`else
  assign sat_count = '0;
`endif

  assign VSYNC_OUT   = vs_d2_q;
  assign HSYNC_OUT   = vld_s2_q;
  assign DATA_R0_OUT = out0.r;
  assign DATA_G0_OUT = out0.g;
  assign DATA_B0_OUT = out0.b;
  assign DATA_R1_OUT = out1.r;
  assign DATA_G1_OUT = out1.g;
  assign DATA_B1_OUT = out1.b;
  assign row_idx     = row_o_q;
  assign frame_done  = fdone_q;
  assign err         = err_q;

endmodule

// File: tb/tb_pixel_stream_proc.sv
// Self-checking bench for pixel_stream_proc (WIDTH=8, HEIGHT=2).
// Reference model computes pixel results from the arithmetic rules.
module tb_pixel_stream_proc;

  localparam int W = 8;
  localparam int H = 2;
  localparam int V = 100;
  localparam int T = 90;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [1:0]  mode;
  logic        VSYNC_IN, HSYNC_IN;
  logic [7:0]  r0, g0, b0, r1, g1, b1;
  logic        VSYNC_OUT, HSYNC_OUT;
  logic [7:0]  R0o, G0o, B0o, R1o, G1o, B1o;
  logic [9:0]  row_idx;
  logic        frame_done;
  logic [2:0]  err;
  logic [19:0] sat_count;

  always #5 HCLK = ~HCLK;

  pixel_stream_proc #(
    .WIDTH(W), .HEIGHT(H), .VALUE(V), .THRESHOLD(T)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .mode(mode),
    .VSYNC_IN(VSYNC_IN), .HSYNC_IN(HSYNC_IN),
    .DATA_R0_IN(r0), .DATA_G0_IN(g0), .DATA_B0_IN(b0),
    .DATA_R1_IN(r1), .DATA_G1_IN(g1), .DATA_B1_IN(b1),
    .VSYNC_OUT(VSYNC_OUT), .HSYNC_OUT(HSYNC_OUT),
    .DATA_R0_OUT(R0o), .DATA_G0_OUT(G0o), .DATA_B0_OUT(B0o),
    .DATA_R1_OUT(R1o), .DATA_G1_OUT(G1o), .DATA_B1_OUT(B1o),
    .row_idx(row_idx), .frame_done(frame_done),
    .err(err), .sat_count(sat_count)
  );

  int errors = 0;
  int checks = 0;

  bit          pv[2];
  bit          pvs[2];
  logic [47:0] pd[2];
  int          prow[2];
  int          pcl[2];
  logic [47:0] last_d;
  int          last_row;
  int          sat_exp;
  logic [2:0]  err_exp;
  logic [1:0]  fmode;

  task automatic check(input string tag, input logic [95:0] obs,
                       input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int chan(input logic [1:0] m, input int x);
    if (m == 2'b01) return (x + V > 255) ? 255 : x + V;
    if (m == 2'b10) return (x < V) ? 0 : x - V;
    return x;
  endfunction

  function automatic logic [23:0] pix(input logic [1:0] m,
                                      input int r, input int g, input int b);
    if (m == 2'b11) return (r + g + b > 3 * T) ? 24'hFFFFFF : 24'h0;
    return {8'(chan(m, r)), 8'(chan(m, g)), 8'(chan(m, b))};
  endfunction

  function automatic int nclamp(input logic [1:0] m, input int x);
    return ((m == 2'b01 && x + V > 255) || (m == 2'b10 && x < V)) ? 1 : 0;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      pv[i] = 0; pvs[i] = 0; pd[i] = '0; prow[i] = 0; pcl[i] = 0;
    end
    last_d = '0; last_row = 0; sat_exp = 0; err_exp = '0;
  endtask

  task automatic set_in(input bit vs, input bit hs);
    VSYNC_IN = vs; HSYNC_IN = hs;
    r0 = 8'($urandom); g0 = 8'($urandom); b0 = 8'($urandom);
    r1 = 8'($urandom); g1 = 8'($urandom); b1 = 8'($urandom);
  endtask

  // One clock: model what the current inputs should produce, then compare
  task automatic step(input bit acc, input int row, input bit fd,
                      input bit arm);
    logic [47:0] d;
    int nc;
    d = {pix(fmode, r0, g0, b0), pix(fmode, r1, g1, b1)};
    nc = nclamp(fmode, r0) + nclamp(fmode, g0) + nclamp(fmode, b0)
       + nclamp(fmode, r1) + nclamp(fmode, g1) + nclamp(fmode, b1);
    @(posedge HCLK); #1;
    pv[1] = pv[0]; pd[1] = pd[0]; prow[1] = prow[0]; pcl[1] = pcl[0];
    pvs[1] = pvs[0];
    pv[0] = acc; pd[0] = d; prow[0] = row; pcl[0] = nc; pvs[0] = VSYNC_IN;
    if (arm) sat_exp = 0;
    else if (pv[1]) sat_exp += pcl[1];
    if (pv[1]) begin last_d = pd[1]; last_row = prow[1]; end
    check("hsync_out", HSYNC_OUT, pv[1]);
    check("vsync_out", VSYNC_OUT, pvs[1]);
    check("data", {R0o, G0o, B0o, R1o, G1o, B1o}, last_d);
    check("row_idx", row_idx, last_row);
    check("frame_done", frame_done, fd);
    check("err", err, err_exp);
`ifdef SAT_COUNT_EN
    check("sat_count", sat_count, sat_exp);
`else
    check("sat_count", sat_count, 0);
`endif
  endtask

  task automatic arm_frame(input logic [1:0] m);
    mode = m; fmode = m;
    set_in(1, 0); step(0, 0, 0, 1);
    mode = 2'($urandom);
    set_in(0, 0); step(0, 0, 0, 0);
  endtask

  task automatic line(input int row, input int n);
    for (int i = 0; i < n; i++) begin
      set_in(0, 1); step(1, row, 0, 0);
    end
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(0, 0); step(0, 0, 0, 0);
    end
  endtask

  task automatic finish_frame();
    set_in(0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
  endtask

  initial begin
    mode = 2'b00; fmode = 2'b00;
    set_in(0, 0);
    clear_model();
    repeat (3) @(posedge HCLK);
    #1;
    check("reset_outs", {VSYNC_OUT, HSYNC_OUT, R0o, G0o, B0o, R1o, G1o, B1o,
                         row_idx, frame_done, err, sat_count}, 0);
    HRESETn = 1'b1;
    gap(2);

    // Frame 1: brightness add, clean geometry
    arm_frame(2'b01);
    set_in(0, 1); r0 = 8'd200; g0 = 8'd10; step(1, 0, 0, 0);
    set_in(0, 1); step(1, 0, 0, 0);
    check("add_r0", R0o, 8'd255);
    check("add_g0", G0o, 8'd110);
    line(0, 2);
    gap(2);
    line(1, 4);
    finish_frame();

    // Frame 2: brightness sub, plus a long line
    arm_frame(2'b10);
    set_in(0, 1); b1 = 8'd50; g1 = 8'd160; step(1, 0, 0, 0);
    set_in(0, 1); step(1, 0, 0, 0);
    check("sub_b1", B1o, 8'd0);
    check("sub_g1", G1o, 8'd60);
    line(0, 2);
    set_in(0, 1); err_exp[1] = 1'b1; step(0, 0, 0, 0);
    gap(1);
    line(1, 4);
    finish_frame();

    // Frame 3: threshold boundary, plus a short line
    arm_frame(2'b11);
    set_in(0, 1);
    r0 = 8'd90; g0 = 8'd90; b0 = 8'd90;
    r1 = 8'd91; g1 = 8'd90; b1 = 8'd90;
    step(1, 0, 0, 0);
    set_in(0, 1); step(1, 0, 0, 0);
    check("thr_px0", {R0o, G0o, B0o}, 24'h000000);
    check("thr_px1", {R1o, G1o, B1o}, 24'hFFFFFF);
    set_in(0, 0); err_exp[0] = 1'b1; step(0, 0, 0, 0);
    line(1, 4);
    finish_frame();

    // Frame 4: VSYNC abort mid-line, then a full restarted frame
    arm_frame(2'b00);
    line(0, 2);
    mode = 2'b01; fmode = 2'b01;
    set_in(1, 0); err_exp[2] = 1'b1; step(0, 0, 0, 1);
    mode = 2'($urandom);
    gap(1);
    line(0, 4);
    gap(2);
    line(1, 4);
    finish_frame();

    // Asynchronous reset mid-line, then a clean frame
    arm_frame(2'b01);
    line(0, 2);
    HRESETn = 1'b0;
    #1;
    check("async_reset_outs", {VSYNC_OUT, HSYNC_OUT, R0o, G0o, B0o, R1o,
                               G1o, B1o, row_idx, frame_done, err,
                               sat_count}, 0);
    clear_model();
    fmode = 2'b00;
    set_in(0, 0);
    #2;
    HRESETn = 1'b1;
    gap(1);
    arm_frame(2'b10);
    line(0, 4);
    gap(1);
    line(1, 4);
    finish_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
